// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter: shares the register-file write port between the ALU and the load unit,
// expands reg_mask_e into a bit mask and splits PCLINK into LR<=pc_i then PC<=data. Optional: REG_WB_RR_EN.
module reg_wb_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [3:0]       alu_reg,
  input  logic [WIDTH-1:0] alu_data,
  input  logic [1:0]       alu_mask,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic [3:0]       mem_reg,
  input  logic [WIDTH-1:0] mem_data,
  input  logic [1:0]       mem_mask,
  input  logic [WIDTH-1:0] pc_i,
  output logic             rf_we,
  output logic [3:0]       rf_sel,
  output logic [WIDTH-1:0] rf_data,
  output logic [WIDTH-1:0] rf_wmask,
  output logic             busy
);

  localparam logic [3:0] REG_LR     = 4'hD;
  localparam logic [3:0] REG_PCLINK = 4'hE;
  localparam logic [3:0] REG_PC     = 4'hF;

  typedef enum logic {IDLE, LINK_PC} state_e;

  function automatic logic [WIDTH-1:0] mask_32(input logic [1:0] m);
    case (m)
      2'd0:    mask_32 = 32'h0000_00ff;
      2'd1:    mask_32 = 32'h0000_ffff;
      2'd2:    mask_32 = 32'h00ff_ffff;
      default: mask_32 = 32'hffff_ffff;
    endcase
  endfunction

  state_e           state_q, state_d;
  logic             rf_we_q, rf_we_d;
  logic [3:0]       rf_sel_q, rf_sel_d;
  logic [WIDTH-1:0] rf_data_q, rf_data_d;
  logic [WIDTH-1:0] rf_wmask_q, rf_wmask_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  logic [1:0]       hold_mask_q, hold_mask_d;

  logic             g_any;
  logic [3:0]       g_reg;
  logic [WIDTH-1:0] g_data;
  logic [1:0]       g_mask;

`ifdef REG_WB_RR_EN
  // Pointer set means the ALU wins the next tie.
  logic rr_alu_q, rr_alu_d;
`endif

  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (state_q == IDLE) begin
`ifdef REG_WB_RR_EN
      if (mem_valid && alu_valid) begin
        mem_ready = ~rr_alu_q;
        alu_ready = rr_alu_q;
      end else begin
        mem_ready = mem_valid;
        alu_ready = alu_valid;
      end
`else
      mem_ready = mem_valid;
      alu_ready = alu_valid & ~mem_valid;
`endif
    end
  end

  assign g_any  = alu_ready | mem_ready;
  assign g_reg  = mem_ready ? mem_reg  : alu_reg;
  assign g_data = mem_ready ? mem_data : alu_data;
  assign g_mask = mem_ready ? mem_mask : alu_mask;

  always_comb begin
    state_d     = state_q;
    rf_we_d     = 1'b0;
    rf_sel_d    = rf_sel_q;
    rf_data_d   = rf_data_q;
    rf_wmask_d  = rf_wmask_q;
    hold_data_d = hold_data_q;
    hold_mask_d = hold_mask_q;
    case (state_q)
      LINK_PC: begin
        rf_we_d    = 1'b1;
        rf_sel_d   = REG_PC;
        rf_data_d  = hold_data_q;
        rf_wmask_d = mask_32(hold_mask_q);
        state_d    = IDLE;
      end
      default: begin
        if (g_any) begin
          rf_we_d = 1'b1;
          if (g_reg == REG_PCLINK) begin
            // LR gets the PC now; the requested PC write is replayed next cycle.
            rf_sel_d    = REG_LR;
            rf_data_d   = pc_i;
            rf_wmask_d  = '1;
            hold_data_d = g_data;
            hold_mask_d = g_mask;
            state_d     = LINK_PC;
          end else begin
            rf_sel_d   = g_reg;
            rf_data_d  = g_data;
            rf_wmask_d = mask_32(g_mask);
          end
        end
      end
    endcase
  end

`ifdef REG_WB_RR_EN
  assign rr_alu_d = g_any ? mem_ready : rr_alu_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rf_we_q     <= 1'b0;
      rf_sel_q    <= '0;
      rf_data_q   <= '0;
      rf_wmask_q  <= '0;
      hold_data_q <= '0;
      hold_mask_q <= '0;
`ifdef REG_WB_RR_EN
      rr_alu_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rf_we_q     <= rf_we_d;
      rf_sel_q    <= rf_sel_d;
      rf_data_q   <= rf_data_d;
      rf_wmask_q  <= rf_wmask_d;
      hold_data_q <= hold_data_d;
      hold_mask_q <= hold_mask_d;
`ifdef REG_WB_RR_EN
      rr_alu_q    <= rr_alu_d;
`endif
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_sel   = rf_sel_q;
  assign rf_data  = rf_data_q;
  assign rf_wmask = rf_wmask_q;
  assign busy     = (state_q == LINK_PC);

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: directed vector table, reset-during-PCLINK sequence,
// then random traffic against a cycle-level reference model.
module tb_reg_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready, mem_valid, mem_ready;
  logic [3:0]  alu_reg, mem_reg, rf_sel;
  logic [31:0] alu_data, mem_data, pc_i, rf_data, rf_wmask;
  logic [1:0]  alu_mask, mem_mask;
  logic        rf_we, busy;

  int n_checks = 0;
  int n_fail   = 0;

  reg_wb_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg),
    .alu_data(alu_data), .alu_mask(alu_mask),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg),
    .mem_data(mem_data), .mem_mask(mem_mask),
    .pc_i(pc_i), .rf_we(rf_we), .rf_sel(rf_sel), .rf_data(rf_data),
    .rf_wmask(rf_wmask), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic av; logic [3:0] ar; logic [31:0] ad; logic [1:0] am;
    logic mv; logic [3:0] mr; logic [31:0] md; logic [1:0] mm;
    logic [31:0] pc;
    logic e_ar, e_mr, e_we; logic [3:0] e_sel; logic [31:0] e_data, e_mask; logic e_busy;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(
    input logic av, input logic [3:0] ar, input logic [31:0] ad, input logic [1:0] am,
    input logic mv, input logic [3:0] mr, input logic [31:0] md, input logic [1:0] mm,
    input logic [31:0] pc, input logic e_ar, input logic e_mr, input logic e_we,
    input logic [3:0] e_sel, input logic [31:0] e_data, input logic [31:0] e_mask,
    input logic e_busy);
    vec_t v;
    v.av = av; v.ar = ar; v.ad = ad; v.am = am;
    v.mv = mv; v.mr = mr; v.md = md; v.mm = mm; v.pc = pc;
    v.e_ar = e_ar; v.e_mr = e_mr; v.e_we = e_we; v.e_sel = e_sel;
    v.e_data = e_data; v.e_mask = e_mask; v.e_busy = e_busy;
    return v;
  endfunction

  // Mask encoding: 0..3 select the low 8/16/24/32 bits.
  function automatic logic [31:0] ref_mask(input logic [1:0] m);
    int bits;
    logic [63:0] one;
    bits = 8 * (int'(m) + 1);
    one  = 64'd1;
    return 32'((one << bits) - one);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic we, input logic [3:0] sel,
                          input logic [31:0] data, input logic [31:0] mask, input logic bz);
    chk({tag, " rf_we"}, 32'(rf_we), 32'(we));
    chk({tag, " rf_sel"}, 32'(rf_sel), 32'(sel));
    chk({tag, " rf_data"}, rf_data, data);
    chk({tag, " rf_wmask"}, rf_wmask, mask);
    chk({tag, " busy"}, 32'(busy), 32'(bz));
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_reg = 0; alu_data = 0; alu_mask = 0;
    mem_valid = 0; mem_reg = 0; mem_data = 0; mem_mask = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  // Reference model state
  logic        m_link, m_ptr_alu, m_we;
  logic [3:0]  m_sel;
  logic [31:0] m_data, m_mask, m_pdata;
  logic [1:0]  m_pmask;

  function automatic logic [3:0] rand_reg();
    if ($urandom_range(0, 3) == 0) return 4'hE;
    return 4'($urandom_range(0, 15));
  endfunction

  initial begin
    logic ga, gm, last_ga, last_gm;
    logic [3:0]  r;
    logic [31:0] d;
    logic [1:0]  m;

    rst = 1; pc_i = 0; idle_inputs();
    #1;
    chk_outs("reset", 0, 4'h0, 32'h0, 32'h0, 0);
    chk("reset alu_ready", 32'(alu_ready), 32'd0);
    chk("reset mem_ready", 32'(mem_ready), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 0;

    tbl[0]  = mk(1,4'h3,32'h12345678,2'd1, 0,4'h0,32'h0,2'd0, 32'h0,   1,0,1,4'h3,32'h12345678,32'h0000ffff,0);
    tbl[1]  = mk(0,4'h0,32'h0,2'd0,        0,4'h0,32'h0,2'd0, 32'h0,   0,0,0,4'h3,32'h12345678,32'h0000ffff,0);
    tbl[2]  = mk(0,4'h0,32'h0,2'd0,        1,4'h1,32'h11111111,2'd3, 32'h0, 0,1,1,4'h1,32'h11111111,32'hffffffff,0);
    tbl[3]  = mk(0,4'h0,32'h0,2'd0,        1,4'h2,32'h22222222,2'd3, 32'h0, 0,1,1,4'h2,32'h22222222,32'hffffffff,0);
    tbl[4]  = mk(0,4'h0,32'h0,2'd0,        1,4'h4,32'h44444444,2'd3, 32'h0, 0,1,1,4'h4,32'h44444444,32'hffffffff,0);
    tbl[5]  = mk(1,4'hE,32'h00000400,2'd2, 0,4'h0,32'h0,2'd0, 32'h100, 1,0,1,4'hD,32'h00000100,32'hffffffff,1);
    tbl[6]  = mk(0,4'h0,32'h0,2'd0,        1,4'h5,32'h55,2'd0, 32'h999, 0,0,1,4'hF,32'h00000400,32'h00ffffff,0);
    tbl[7]  = mk(0,4'h0,32'h0,2'd0,        1,4'h5,32'h55,2'd0, 32'h999, 0,1,1,4'h5,32'h55,32'h000000ff,0);
    tbl[8]  = mk(1,4'h6,32'h66,2'd3,       0,4'h0,32'h0,2'd0, 32'h0,   1,0,1,4'h6,32'h66,32'hffffffff,0);
`ifdef REG_WB_RR_EN
    tbl[9]  = mk(1,4'h6,32'h66,2'd3, 1,4'h7,32'h77,2'd1, 32'h0, 0,1,1,4'h7,32'h77,32'h0000ffff,0);
    tbl[10] = mk(1,4'h6,32'h66,2'd3, 1,4'h7,32'h77,2'd1, 32'h0, 1,0,1,4'h6,32'h66,32'hffffffff,0);
    tbl[11] = mk(1,4'h6,32'h66,2'd3, 1,4'h7,32'h77,2'd1, 32'h0, 0,1,1,4'h7,32'h77,32'h0000ffff,0);
    tbl[12] = mk(1,4'h6,32'h66,2'd3, 1,4'h7,32'h77,2'd1, 32'h0, 1,0,1,4'h6,32'h66,32'hffffffff,0);
    tbl[13] = mk(0,4'h0,32'h0,2'd0,  0,4'h0,32'h0,2'd0,  32'h0, 0,0,0,4'h6,32'h66,32'hffffffff,0);
`else
    tbl[9]  = mk(1,4'h6,32'h66,2'd3, 1,4'h7,32'h77,2'd1, 32'h0, 0,1,1,4'h7,32'h77,32'h0000ffff,0);
    tbl[10] = mk(1,4'h6,32'h66,2'd3, 1,4'h7,32'h77,2'd1, 32'h0, 0,1,1,4'h7,32'h77,32'h0000ffff,0);
    tbl[11] = mk(1,4'h6,32'h66,2'd3, 1,4'h7,32'h77,2'd1, 32'h0, 0,1,1,4'h7,32'h77,32'h0000ffff,0);
    tbl[12] = mk(1,4'h6,32'h66,2'd3, 1,4'h7,32'h77,2'd1, 32'h0, 0,1,1,4'h7,32'h77,32'h0000ffff,0);
    tbl[13] = mk(0,4'h0,32'h0,2'd0,  0,4'h0,32'h0,2'd0,  32'h0, 0,0,0,4'h7,32'h77,32'h0000ffff,0);
`endif
    tbl[14] = mk(1,4'hF,32'h00000800,2'd0, 0,4'h0,32'h0,2'd0, 32'h0, 1,0,1,4'hF,32'h00000800,32'h000000ff,0);
    tbl[15] = mk(0,4'h0,32'h0,2'd0,        0,4'h0,32'h0,2'd0, 32'h0, 0,0,0,4'hF,32'h00000800,32'h000000ff,0);

    for (int i = 0; i < 16; i++) begin
      alu_valid = tbl[i].av; alu_reg = tbl[i].ar; alu_data = tbl[i].ad; alu_mask = tbl[i].am;
      mem_valid = tbl[i].mv; mem_reg = tbl[i].mr; mem_data = tbl[i].md; mem_mask = tbl[i].mm;
      pc_i = tbl[i].pc;
      #1;
      chk($sformatf("vec%0d alu_ready", i), 32'(alu_ready), 32'(tbl[i].e_ar));
      chk($sformatf("vec%0d mem_ready", i), 32'(mem_ready), 32'(tbl[i].e_mr));
      @(posedge clk); #1;
      chk_outs($sformatf("vec%0d", i), tbl[i].e_we, tbl[i].e_sel, tbl[i].e_data,
               tbl[i].e_mask, tbl[i].e_busy);
      @(negedge clk);
    end

    // Reset while the PC half of a PCLINK is pending.
    idle_inputs();
    alu_valid = 1; alu_reg = 4'hE; alu_data = 32'h1234; alu_mask = 2'd3; pc_i = 32'h200;
    #1;
    chk("rstlink alu_ready", 32'(alu_ready), 32'd1);
    @(posedge clk); #1;
    chk_outs("rstlink LR", 1, 4'hD, 32'h200, 32'hffffffff, 1);
    @(negedge clk);
    idle_inputs(); rst = 1;
    #1;
    chk_outs("rstlink in reset", 0, 4'h0, 32'h0, 32'h0, 0);
    @(posedge clk); #1;
    chk_outs("rstlink held reset", 0, 4'h0, 32'h0, 32'h0, 0);
    @(negedge clk);
    rst = 0;
    mem_valid = 1; mem_reg = 4'h9; mem_data = 32'h99; mem_mask = 2'd1;
    #1;
    chk("rstlink mem_ready", 32'(mem_ready), 32'd1);
    @(posedge clk); #1;
    chk_outs("rstlink after", 1, 4'h9, 32'h99, 32'h0000ffff, 0);
    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;
    chk_outs("rstlink no PC", 0, 4'h9, 32'h99, 32'h0000ffff, 0);

    // Random traffic against the reference model.
    do_reset();
    m_link = 0; m_ptr_alu = 0; m_we = 0; m_sel = 0; m_data = 0; m_mask = 0;
    m_pdata = 0; m_pmask = 0;
    last_ga = 0; last_gm = 0;
    for (int c = 0; c < 400; c++) begin
      if (!alu_valid || last_ga) begin
        alu_valid = ($urandom_range(0, 2) != 0); alu_reg = rand_reg();
        alu_data = $urandom; alu_mask = 2'($urandom_range(0, 3));
      end
      if (!mem_valid || last_gm) begin
        mem_valid = ($urandom_range(0, 2) != 0); mem_reg = rand_reg();
        mem_data = $urandom; mem_mask = 2'($urandom_range(0, 3));
      end
      pc_i = $urandom;
      #1;
      ga = 0; gm = 0;
      if (!m_link) begin
        if (mem_valid && alu_valid) begin
`ifdef REG_WB_RR_EN
          if (m_ptr_alu) ga = 1; else gm = 1;
`else
          gm = 1;
`endif
        end else begin
          gm = mem_valid; ga = alu_valid;
        end
      end
      chk($sformatf("rnd%0d alu_ready", c), 32'(alu_ready), 32'(ga));
      chk($sformatf("rnd%0d mem_ready", c), 32'(mem_ready), 32'(gm));
      @(posedge clk);
      if (m_link) begin
        m_we = 1; m_sel = 4'hF; m_data = m_pdata; m_mask = ref_mask(m_pmask); m_link = 0;
      end else if (ga || gm) begin
        r = gm ? mem_reg : alu_reg; d = gm ? mem_data : alu_data; m = gm ? mem_mask : alu_mask;
        m_we = 1;
        if (r == 4'hE) begin
          m_sel = 4'hD; m_data = pc_i; m_mask = 32'hffffffff;
          m_link = 1; m_pdata = d; m_pmask = m;
        end else begin
          m_sel = r; m_data = d; m_mask = ref_mask(m);
        end
        m_ptr_alu = gm;
      end else begin
        m_we = 0;
      end
      #1;
      chk_outs($sformatf("rnd%0d", c), m_we, m_sel, m_data, m_mask, m_link);
      last_ga = ga; last_gm = gm;
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
